// File: rtl/simple_cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU: data width and opcode encodings.
package simple_cpu_pkg;

   localparam int DATA_W = 8;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_LDH  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_STA  = 4'hA;
   localparam logic [3:0] OP_LDA  = 4'hB;
   localparam logic [3:0] OP_ADDR = 4'hC;
   localparam logic [3:0] OP_SUBR = 4'hD;
   localparam logic [3:0] OP_CLR  = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   // Opcodes that produce a carry/borrow; every other opcode leaves the flag alone.
   function automatic logic is_arith(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDR) || (op == OP_SUBR);
   endfunction

   // Opcodes whose operand comes from the register file instead of imm4.
   function automatic logic uses_reg(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_ADDR) || (op == OP_SUBR);
   endfunction

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational datapath: computes the new accumulator value and carry/borrow for one opcode.
module simple_cpu_alu
   import simple_cpu_pkg::*;
(
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              writes_acc
);

   logic [DATA_W:0] sum_s;
   logic [DATA_W:0] diff_s;

   assign sum_s  = {1'b0, acc} + {1'b0, operand};
   // Top bit of the 9-bit difference is set exactly when operand > acc (borrow).
   assign diff_s = {1'b0, acc} - {1'b0, operand};

   // Opcode decode and result selection
   always_comb begin
      result     = acc;
      carry      = 1'b0;
      writes_acc = 1'b1;
      case (opcode)
         OP_ADD, OP_ADDR: begin
            result = sum_s[DATA_W-1:0];
            carry  = sum_s[DATA_W];
         end
         OP_SUB, OP_SUBR: begin
            result = diff_s[DATA_W-1:0];
            carry  = diff_s[DATA_W];
         end
         OP_AND:  result = acc & operand;
         OP_OR:   result = acc | operand;
         OP_XOR:  result = acc ^ operand;
         OP_LDI:  result = operand;
         OP_LDH:  result = {operand[3:0], acc[3:0]};
         OP_NOT:  result = ~acc;
         OP_SHL:  result = acc << operand[2:0];
         OP_SHR:  result = acc >> operand[2:0];
         OP_STA:  writes_acc = 1'b0;
         OP_LDA:  result = operand;
         OP_CLR:  result = 8'h00;
         OP_NOP:  writes_acc = 1'b0;
         default: writes_acc = 1'b0;
      endcase
   end

endmodule

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit accumulator CPU: acc, flags and a four-entry register file around simple_cpu_alu.
module simple_cpu
   import simple_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  instruction,
   output logic [7:0]  acc,
   output logic        zero_flag,
   output logic        carry_flag
);

   logic [3:0]        opcode_s;
   logic [3:0]        imm_s;
   logic [1:0]        rsel_s;
   logic [DATA_W-1:0] operand_s;
   logic [DATA_W-1:0] result_s;
   logic              carry_s;
   logic              writes_acc_s;

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];

   assign opcode_s  = instruction[7:4];
   assign imm_s     = instruction[3:0];
   assign rsel_s    = imm_s[1:0];
   assign operand_s = uses_reg(opcode_s) ? regs_q[rsel_s] : {4'b0000, imm_s};

   simple_cpu_alu u_alu (
      .opcode     (opcode_s),
      .acc        (acc_q),
      .operand    (operand_s),
      .result     (result_s),
      .carry      (carry_s),
      .writes_acc (writes_acc_s)
   );

   // Next-state for accumulator, flags and register file
   always_comb begin
      regs_d = regs_q;
      if (opcode_s == OP_STA) begin
         regs_d[rsel_s] = acc_q;
      end else begin
         regs_d = regs_q;
      end
      if (writes_acc_s) begin
         acc_d  = result_s;
         zero_d = (result_s == 8'h00);
      end else begin
         acc_d  = acc_q;
         zero_d = zero_q;
      end
      if (is_arith(opcode_s)) begin
         carry_d = carry_s;
      end else begin
         carry_d = carry_q;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q   <= 8'h00;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         acc_q   <= acc_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         regs_q  <= regs_d;
      end
   end

   assign acc        = acc_q;
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;

endmodule

// File: tb/tb_simple_cpu.sv
// Directed self-checking bench for simple_cpu with hand-computed expected values.
module tb_simple_cpu;

   logic       clk;
   logic       reset;
   logic [7:0] instruction;
   logic [7:0] acc;
   logic       zero_flag;
   logic       carry_flag;

   int pass_cnt;
   int total_cnt;

   simple_cpu dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .acc         (acc),
      .zero_flag   (zero_flag),
      .carry_flag  (carry_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one instruction away from the edge, then sample 1 time unit after the edge.
   task automatic step(input logic [7:0] instr);
      @(negedge clk);
      instruction = instr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] a, input logic z, input logic c);
      chk({tag, "_acc"},   acc,               a);
      chk({tag, "_zero"},  {7'd0, zero_flag}, {7'd0, z});
      chk({tag, "_carry"}, {7'd0, carry_flag},{7'd0, c});
   endtask

   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      reset       = 1'b0;
      instruction = 8'hF0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      step(8'h01); chk_all("add1",   8'h01, 1'b0, 1'b0);
      step(8'h11); chk_all("sub_z",  8'h00, 1'b1, 1'b0);
      step(8'h11); chk_all("sub_bw", 8'hFF, 1'b0, 1'b1);

      step(8'h5F); chk_all("ldi_f",  8'h0F, 1'b0, 1'b1);
      step(8'h6F); chk_all("ldh_f",  8'hFF, 1'b0, 1'b1);
      step(8'h01); chk_all("wrap",   8'h00, 1'b1, 1'b1);

      step(8'h55); chk_all("ldi5",   8'h05, 1'b0, 1'b1);
      step(8'hA2); chk_all("sta2",   8'h05, 1'b0, 1'b1);
      step(8'hE0); chk_all("clr",    8'h00, 1'b1, 1'b1);
      step(8'hA1); chk_all("sta1_z", 8'h00, 1'b1, 1'b1);
      step(8'hB2); chk_all("lda2",   8'h05, 1'b0, 1'b1);
      step(8'hC2); chk_all("addr2",  8'h0A, 1'b0, 1'b0);
      step(8'hD2); chk_all("subr2",  8'h05, 1'b0, 1'b0);
      step(8'hB1); chk_all("lda1",   8'h00, 1'b1, 1'b0);
      step(8'hD2); chk_all("subr_bw",8'hFB, 1'b0, 1'b1);

      step(8'h53); chk_all("ldi3",   8'h03, 1'b0, 1'b1);
      step(8'h82); chk_all("shl2",   8'h0C, 1'b0, 1'b1);
      step(8'h4F); chk_all("xorf",   8'h03, 1'b0, 1'b1);
      step(8'h70); chk_all("not",    8'hFC, 1'b0, 1'b1);
      step(8'h93); chk_all("shr3",   8'h1F, 1'b0, 1'b1);
      step(8'h33); chk_all("or3",    8'h1F, 1'b0, 1'b1);
      step(8'h2C); chk_all("andc",   8'h0C, 1'b0, 1'b1);
      step(8'h70); chk_all("not2",   8'hF3, 1'b0, 1'b1);
      step(8'h20); chk_all("and0",   8'h00, 1'b1, 1'b1);
      step(8'h55); step(8'h8F); chk_all("shl7", 8'h80, 1'b0, 1'b1);
      step(8'h53); step(8'h82); step(8'h4F); step(8'h70);
      chk_all("refc", 8'hFC, 1'b0, 1'b1);
      step(8'hF0); chk_all("nop",    8'hFC, 1'b0, 1'b1);

      // Asynchronous reset between edges; check before the next rising edge.
      instruction = 8'h01;
      #2;
      reset = 1'b0;
      #1;
      chk_all("areset", 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk_all("areset_hold", 8'h00, 1'b1, 1'b0);
      reset = 1'b1;
      step(8'hB2); chk_all("regs_clr", 8'h00, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
